// File: rtl/rf_issue_scoreboard.sv
// Dual-issue RAW/capacity scoreboard in front of the register-file read stage.
// Each architectural register carries a saturating count of in-flight writers.
module rf_issue_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int STALL_W = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               eu0_valid_in,
    input  logic               eu0_rd_we_in,
    input  logic               eu0_rj_use_in,
    input  logic               eu0_rk_use_in,
    input  logic [4:0]         eu0_rd_in,
    input  logic [4:0]         eu0_rj_in,
    input  logic [4:0]         eu0_rk_in,
    input  logic               eu1_valid_in,
    input  logic               eu1_rd_we_in,
    input  logic               eu1_rj_use_in,
    input  logic               eu1_rk_use_in,
    input  logic [4:0]         eu1_rd_in,
    input  logic [4:0]         eu1_rj_in,
    input  logic [4:0]         eu1_rk_in,
    input  logic               write_en_0,
    input  logic               write_en_1,
    input  logic [4:0]         write_addr_0,
    input  logic [4:0]         write_addr_1,
    output logic               issue0,
    output logic               issue1,
    output logic [31:0]        busy_vec,
    output logic               underflow_err,
    output logic [STALL_W-1:0] stall_cnt
);
    // Wide enough to hold cnt + 2 issues and MAX + 2 writebacks without wrapping.
    localparam int               SUM_W   = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [1:0]         wb_cnt [32];
    logic [31:0]        busy_q, busy_d;
    logic               underflow_q, underflow_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [SUM_W-1:0]   occ;

    logic rj0_ok, rk0_ok, rd0_ok;
    logic rj1_ok, rk1_ok, rd1_ok;
    logic same_rd, pair_raw;

    function automatic logic src_ok(input logic use_src, input logic [CNT_W-1:0] cnt,
                                    input logic [1:0] wb);
        return !use_src || cnt == '0 || (cnt == CNT_W'(1) && wb != 2'd0);
    endfunction

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            wb_cnt[r] = 2'(write_en_0 && write_addr_0 == 5'(r))
                      + 2'(write_en_1 && write_addr_1 == 5'(r));
        end
        wb_cnt[0] = 2'd0;
    end

    always_comb begin
        rj0_ok = src_ok(eu0_rj_use_in, cnt_q[eu0_rj_in], wb_cnt[eu0_rj_in]);
        rk0_ok = src_ok(eu0_rk_use_in, cnt_q[eu0_rk_in], wb_cnt[eu0_rk_in]);
        rj1_ok = src_ok(eu1_rj_use_in, cnt_q[eu1_rj_in], wb_cnt[eu1_rj_in]);
        rk1_ok = src_ok(eu1_rk_use_in, cnt_q[eu1_rk_in], wb_cnt[eu1_rk_in]);

        rd0_ok = !eu0_rd_we_in || eu0_rd_in == 5'd0
              || (SUM_W'(cnt_q[eu0_rd_in]) + SUM_W'(1)
                  <= CNT_MAX + SUM_W'(wb_cnt[eu0_rd_in]));

        // A pair writing the same rd needs room for both writers at once.
        same_rd = eu0_rd_we_in && eu1_rd_we_in && eu0_rd_in == eu1_rd_in;
        rd1_ok  = !eu1_rd_we_in || eu1_rd_in == 5'd0
               || (SUM_W'(cnt_q[eu1_rd_in]) + (same_rd ? SUM_W'(2) : SUM_W'(1))
                   <= CNT_MAX + SUM_W'(wb_cnt[eu1_rd_in]));

        pair_raw = eu0_rd_we_in && eu0_rd_in != 5'd0
                && ((eu1_rj_use_in && eu1_rj_in == eu0_rd_in)
                 || (eu1_rk_use_in && eu1_rk_in == eu0_rd_in));

        issue0 = rstn && !flush && eu0_valid_in && rj0_ok && rk0_ok && rd0_ok;
        issue1 = issue0 && eu1_valid_in && rj1_ok && rk1_ok && rd1_ok && !pair_raw;
    end

    // NOTE: every variable written here gets a default first so no path leaves it
    // holding its old value, which would infer a latch.
    always_comb begin
        underflow_d = underflow_q;
        stall_d     = stall_q;
        busy_d      = '0;
        occ         = '0;
        for (int r = 0; r < 32; r++) cnt_d[r] = '0;
        if (!flush) begin
            if (eu0_valid_in && !issue0) stall_d = stall_q + STALL_W'(1);
            for (int r = 1; r < 32; r++) begin
                occ = SUM_W'(cnt_q[r])
                    + SUM_W'(issue0 && eu0_rd_we_in && eu0_rd_in == 5'(r))
                    + SUM_W'(issue1 && eu1_rd_we_in && eu1_rd_in == 5'(r));
                if (occ < SUM_W'(wb_cnt[r])) begin
                    underflow_d = 1'b1;
                end else begin
                    cnt_d[r] = CNT_W'(occ - SUM_W'(wb_cnt[r]));
                end
                busy_d[r] = cnt_d[r] != '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
            busy_q      <= '0;
            underflow_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
            busy_q      <= busy_d;
            underflow_q <= underflow_d;
            stall_q     <= stall_d;
        end
    end

    assign busy_vec      = busy_q;
    assign underflow_err = underflow_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_rf_issue_scoreboard.sv
// Scoreboard bench: driver pushes model expectations, a negedge monitor compares.
module tb_rf_issue_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rstn, flush;
        logic       v0, we0, ju0, ku0;
        logic [4:0] rd0, rj0, rk0;
        logic       v1, we1, ju1, ku1;
        logic [4:0] rd1, rj1, rk1;
        logic       wen0, wen1;
        logic [4:0] wa0, wa1;
    } stim_t;

    typedef struct packed {
        logic        i0, i1;
        logic [31:0] busy;
        logic        uf;
        logic [31:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn, flush;
    logic        eu0_valid_in, eu0_rd_we_in, eu0_rj_use_in, eu0_rk_use_in;
    logic [4:0]  eu0_rd_in, eu0_rj_in, eu0_rk_in;
    logic        eu1_valid_in, eu1_rd_we_in, eu1_rj_use_in, eu1_rk_use_in;
    logic [4:0]  eu1_rd_in, eu1_rj_in, eu1_rk_in;
    logic        write_en_0, write_en_1;
    logic [4:0]  write_addr_0, write_addr_1;
    logic        issue0, issue1;
    logic [31:0] busy_vec;
    logic        underflow_err;
    logic [31:0] stall_cnt;

    int          m_cnt [32];
    bit          m_uf;
    bit   [31:0] m_stall;
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    rf_issue_scoreboard #(.CNT_W(CNT_W), .STALL_W(32)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .eu0_valid_in(eu0_valid_in), .eu0_rd_we_in(eu0_rd_we_in),
        .eu0_rj_use_in(eu0_rj_use_in), .eu0_rk_use_in(eu0_rk_use_in),
        .eu0_rd_in(eu0_rd_in), .eu0_rj_in(eu0_rj_in), .eu0_rk_in(eu0_rk_in),
        .eu1_valid_in(eu1_valid_in), .eu1_rd_we_in(eu1_rd_we_in),
        .eu1_rj_use_in(eu1_rj_use_in), .eu1_rk_use_in(eu1_rk_use_in),
        .eu1_rd_in(eu1_rd_in), .eu1_rj_in(eu1_rj_in), .eu1_rk_in(eu1_rk_in),
        .write_en_0(write_en_0), .write_en_1(write_en_1),
        .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
        .issue0(issue0), .issue1(issue1), .busy_vec(busy_vec),
        .underflow_err(underflow_err), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("issue0", {31'd0, issue0}, {31'd0, mon_e.i0});
            check("issue1", {31'd0, issue1}, {31'd0, mon_e.i1});
            check("busy_vec", busy_vec, mon_e.busy);
            check("underflow_err", {31'd0, underflow_err}, {31'd0, mon_e.uf});
            check("stall_cnt", stall_cnt, mon_e.stall);
        end
    end

    task automatic apply(input stim_t s);
        rstn = s.rstn; flush = s.flush;
        eu0_valid_in = s.v0; eu0_rd_we_in = s.we0; eu0_rj_use_in = s.ju0; eu0_rk_use_in = s.ku0;
        eu0_rd_in = s.rd0; eu0_rj_in = s.rj0; eu0_rk_in = s.rk0;
        eu1_valid_in = s.v1; eu1_rd_we_in = s.we1; eu1_rj_use_in = s.ju1; eu1_rk_use_in = s.ku1;
        eu1_rd_in = s.rd1; eu1_rj_in = s.rj1; eu1_rk_in = s.rk1;
        write_en_0 = s.wen0; write_en_1 = s.wen1;
        write_addr_0 = s.wa0; write_addr_1 = s.wa1;
    endtask

    // Number of writebacks landing on register r this cycle (r0 writes are discarded).
    function automatic int wbn(input stim_t s, input int r);
        if (r == 0) return 0;
        return int'(s.wen0 && int'(s.wa0) == r) + int'(s.wen1 && int'(s.wa1) == r);
    endfunction

    function automatic bit ready(input stim_t s, input int r);
        return r == 0 || m_cnt[r] == 0 || (m_cnt[r] == 1 && wbn(s, r) > 0);
    endfunction

    // Writers still in flight after this cycle's retirements plus the new ones must fit.
    function automatic bit fits(input stim_t s, input int r, input int new_writers);
        return r == 0 || m_cnt[r] - wbn(s, r) + new_writers <= MAX;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit   i0, i1;
        int   v;
        @(posedge clk);
        #1;
        apply(s);
        i0 = s.rstn && !s.flush && s.v0
          && (!s.ju0 || ready(s, int'(s.rj0))) && (!s.ku0 || ready(s, int'(s.rk0)))
          && (!s.we0 || fits(s, int'(s.rd0), 1));
        i1 = i0 && s.v1
          && (!s.ju1 || ready(s, int'(s.rj1))) && (!s.ku1 || ready(s, int'(s.rk1)))
          && !(s.we0 && s.rd0 != 0 && ((s.ju1 && s.rj1 == s.rd0) || (s.ku1 && s.rk1 == s.rd0)))
          && (!s.we1 || fits(s, int'(s.rd1), (s.we0 && s.rd0 == s.rd1) ? 2 : 1));
        e.i0 = i0;
        e.i1 = i1;
        for (int r = 0; r < 32; r++) e.busy[r] = (m_cnt[r] != 0);
        e.uf    = m_uf;
        e.stall = m_stall;
        exp_q.push_back(e);
        if (!s.rstn) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_uf    = 1'b0;
            m_stall = '0;
        end else if (s.flush) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            if (s.v0 && !i0) m_stall = m_stall + 1;
            for (int r = 1; r < 32; r++) begin
                v = m_cnt[r] + int'(i0 && s.we0 && int'(s.rd0) == r)
                             + int'(i1 && s.we1 && int'(s.rd1) == r) - wbn(s, r);
                if (v < 0) begin
                    v    = 0;
                    m_uf = 1'b1;
                end
                m_cnt[r] = v;
            end
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s      = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    function automatic logic [4:0] pick_wb();
        int start;
        start = $urandom_range(0, 7);
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++) begin
            if (m_cnt[(start + k) % 8] > 0) return 5'((start + k) % 8);
        end
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s       = idle();
        s.rstn  = ($urandom_range(0, 399) != 0);
        s.flush = ($urandom_range(0, 29) == 0);
        s.v0 = 1'($urandom); s.we0 = 1'($urandom); s.ju0 = 1'($urandom); s.ku0 = 1'($urandom);
        s.rd0 = 5'($urandom_range(0, 7)); s.rj0 = 5'($urandom_range(0, 7)); s.rk0 = 5'($urandom_range(0, 7));
        s.v1 = 1'($urandom); s.we1 = 1'($urandom); s.ju1 = 1'($urandom); s.ku1 = 1'($urandom);
        s.rd1 = 5'($urandom_range(0, 7)); s.rj1 = 5'($urandom_range(0, 7)); s.rk1 = 5'($urandom_range(0, 7));
        s.wen0 = ($urandom_range(0, 2) == 0); s.wa0 = pick_wb();
        s.wen1 = ($urandom_range(0, 3) == 0); s.wa1 = pick_wb();
        return s;
    endfunction

    initial begin
        stim_t s;
        s      = idle();
        s.rstn = 1'b0;
        apply(s);
        repeat (3) @(posedge clk);
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_uf    = 1'b0;
        m_stall = '0;

        // Writer to r5, dependent reader stalls, then issues on same-cycle writeback.
        s = idle(); s.v0 = 1; s.we0 = 1; s.rd0 = 5; drive(s);
        s = idle(); s.v0 = 1; s.ju0 = 1; s.rj0 = 5; drive(s);
        s.wen0 = 1; s.wa0 = 5; drive(s);
        drive(idle());

        // Intra-pair RAW on r3.
        s = idle(); s.v0 = 1; s.we0 = 1; s.rd0 = 3; s.v1 = 1; s.ju1 = 1; s.rj1 = 3; drive(s);
        s = idle(); s.v0 = 1; s.ju0 = 1; s.rj0 = 3; drive(s);
        s.wen0 = 1; s.wa0 = 3; drive(s);

        // Saturate r7, fourth writer stalls until a same-cycle writeback frees a slot.
        s = idle(); s.v0 = 1; s.we0 = 1; s.rd0 = 7;
        repeat (4) drive(s);
        s.wen1 = 1; s.wa1 = 7; drive(s);

        // Pair writing r9 with two already pending: only slot 0 fits.
        s = idle(); s.v0 = 1; s.we0 = 1; s.rd0 = 9;
        repeat (2) drive(s);
        s.v1 = 1; s.we1 = 1; s.rd1 = 9; drive(s);
        drive(idle());

        // Flush with pending r4/r6 and a writeback to r4.
        s = idle(); s.v0 = 1; s.we0 = 1; s.rd0 = 4; s.v1 = 1; s.we1 = 1; s.rd1 = 6; drive(s);
        s = idle(); s.flush = 1; s.v0 = 1; s.wen0 = 1; s.wa0 = 4; drive(s);
        drive(idle());
        s = idle(); s.v0 = 1; s.ju0 = 1; s.rj0 = 6; drive(s);

        // r0 is never tracked; then a genuine underflow on r12.
        s = idle(); s.v0 = 1; s.we0 = 1; s.rd0 = 0; s.wen1 = 1; s.wa1 = 0; drive(s);
        s = idle(); s.v0 = 1; s.ju0 = 1; s.ku0 = 1; drive(s);
        s = idle(); s.wen0 = 1; s.wa0 = 12; drive(s);
        drive(idle());

        // Reset with a valid slot 0 must not issue.
        s = idle(); s.rstn = 0; s.v0 = 1; drive(s);
        drive(idle());

        for (int n = 0; n < 3000; n++) drive(rand_stim());
        drive(idle());

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
